// File: rtl/joint_rcservo_multi.sv
// N-channel RC-servo joint: per-channel rate integrator with symmetric clamp and frame-latched PWM.
// Define JOINT_RCSERVO_STAGGER_EN to start channel i's pulse at i*STAGGER_STEP instead of 0.
module joint_rcservo_multi #(
  parameter int NUM_CH       = 4,
  parameter int SERVO_FREQ   = 480000,
  parameter int SERVO_CENTER = 72000,
  parameter int SERVO_MINMAX = 72000,
  parameter int POS_SHIFT    = 8,
  parameter int STAGGER_STEP = 8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     enable,
  input  logic [32*NUM_CH-1:0]  jointFreqCmd,
  output logic [32*NUM_CH-1:0]  jointFeedback,
  output logic [NUM_CH-1:0]     PWM,
  output logic [NUM_CH-1:0]     limit
);

`ifdef JOINT_RCSERVO_STAGGER_EN
  localparam bit StaggerEn = 1'b1;
`else
  localparam bit StaggerEn = 1'b0;
`endif

  localparam logic [31:0]        FreqLast = 32'(SERVO_FREQ - 1);
  localparam logic [31:0]        Center   = 32'(SERVO_CENTER);
  localparam logic signed [63:0] MinMax   = 64'(SERVO_MINMAX);

  logic [31:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = (fcnt_q >= FreqLast) ? 32'd0 : fcnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt_q <= 32'd0;
    else     fcnt_q <= fcnt_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    localparam logic [31:0] Start = StaggerEn ? 32'(g * STAGGER_STEP) : 32'd0;

    logic [31:0]        cmd, mag, posScaled;
    logic               cmdPos, cmdNeg, incOk, decOk, due;
    logic signed [63:0] posExt;
    logic [31:0]        rate_q, rate_d;
    logic signed [31:0] pos_q, pos_d;
    logic [31:0]        width_q, width_d;
    logic               armed_q, armed_d;
    logic               pwm_q, pwm_d;
    logic               lim_q, lim_d;

    assign cmd       = jointFreqCmd[32*g +: 32];
    assign cmdNeg    = cmd[31];
    assign cmdPos    = !cmd[31] && (cmd != 32'd0);
    assign mag       = cmdNeg ? (~cmd + 32'd1) : cmd;
    assign due       = rate_q >= (mag - 32'd1);
    assign posScaled = pos_q << POS_SHIFT;

    // Clamp test done in 64 bits so extreme positions can never wrap.
    assign posExt = {{32{pos_q[31]}}, pos_q};
    assign incOk  = ((posExt + 64'sd1) <<< POS_SHIFT) <= MinMax;
    assign decOk  = ((posExt - 64'sd1) <<< POS_SHIFT) >= -MinMax;

    always_comb begin
      rate_d = rate_q;
      pos_d  = pos_q;
      if (!enable[g]) begin
        rate_d = 32'd0;
      end else if (cmd != 32'd0) begin
        if (due) begin
          rate_d = 32'd0;
          if (cmdPos && incOk)      pos_d = pos_q + 32'sd1;
          else if (cmdNeg && decOk) pos_d = pos_q - 32'sd1;
        end else begin
          rate_d = rate_q + 32'd1;
        end
      end
    end

    // A channel only drives a pulse if it was enabled at its frame start and has stayed enabled.
    always_comb begin
      lim_d   = enable[g] && ((cmdPos && !incOk) || (cmdNeg && !decOk));
      width_d = (fcnt_q == Start) ? Center + posScaled : width_q;
      armed_d = enable[g] && (armed_q || (fcnt_q == Start));
      pwm_d   = armed_d && (fcnt_q >= Start) && ((fcnt_q - Start) < width_q);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rate_q  <= 32'd0;
        pos_q   <= 32'sd0;
        width_q <= Center;
        armed_q <= 1'b0;
        pwm_q   <= 1'b0;
        lim_q   <= 1'b0;
      end else begin
        rate_q  <= rate_d;
        pos_q   <= pos_d;
        width_q <= width_d;
        armed_q <= armed_d;
        pwm_q   <= pwm_d;
        lim_q   <= lim_d;
      end
    end

    assign jointFeedback[32*g +: 32] = pos_q;
    assign PWM[g]   = pwm_q;
    assign limit[g] = lim_q;
  end

endmodule

// File: tb/tb_joint_rcservo_multi.sv
// Self-checking bench for joint_rcservo_multi: vector table, hand-written corner sequences,
// and randomized stimulus compared every cycle against a behavioural model.
module tb_joint_rcservo_multi;

  localparam int NCH    = 2;
  localparam int FREQ   = 1000;
  localparam int CENTER = 500;
  localparam int MINMAX = 256;
  localparam int SHIFT  = 4;
  localparam int SCALE  = 1 << SHIFT;
  localparam int STG    = 200;
`ifdef JOINT_RCSERVO_STAGGER_EN
  localparam int STG_EFF = STG;
`else
  localparam int STG_EFF = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  enable = '0;
  logic [32*NCH-1:0] cmd = '0;
  logic [32*NCH-1:0] fb;
  logic [NCH-1:0]  pwm;
  logic [NCH-1:0]  lim;

  int checks = 0;
  int errors = 0;

  longint mP[NCH], mCnt[NCH], mW[NCH], mF;
  bit     mPwm[NCH], mLim[NCH], mAct[NCH];

  typedef struct {
    logic [1:0]  en;
    logic [31:0] c0;
    logic [31:0] c1;
    int          cycles;
    int          fb0;
    int          fb1;
    logic [1:0]  lim;
    int          pulseCh;
    int          pulseW;
  } vec_t;

  vec_t vecs[10];

  joint_rcservo_multi #(
    .NUM_CH(NCH), .SERVO_FREQ(FREQ), .SERVO_CENTER(CENTER),
    .SERVO_MINMAX(MINMAX), .POS_SHIFT(SHIFT), .STAGGER_STEP(STG)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .jointFreqCmd(cmd),
    .jointFeedback(fb), .PWM(pwm), .limit(lim)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mF = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      mP[ch] = 0; mCnt[ch] = 0; mW[ch] = CENTER;
      mPwm[ch] = 0; mLim[ch] = 0; mAct[ch] = 0;
    end
  endtask

  // One clock edge of the behavioural model, using the values present before the edge.
  task automatic modelStep();
    for (int ch = 0; ch < NCH; ch++) begin
      longint c = longint'(signed'(cmd[32*ch +: 32]));
      bit en = enable[ch];
      longint s = ch * STG_EFF;
      longint m = (c < 0) ? -c : c;
      bit upOk = ((mP[ch] + 1) * SCALE) <= MINMAX;
      bit dnOk = ((mP[ch] - 1) * SCALE) >= -MINMAX;
      if (mF == s) mW[ch] = CENTER + mP[ch] * SCALE;
      if (!en) mAct[ch] = 0;
      else if (mF == s) mAct[ch] = 1;
      mPwm[ch] = en && mAct[ch] && (mF >= s) && (mF < s + mW[ch]);
      mLim[ch] = en && ((c > 0 && !upOk) || (c < 0 && !dnOk));
      if (!en) mCnt[ch] = 0;
      else if (c != 0) begin
        if (mCnt[ch] >= m - 1) begin
          mCnt[ch] = 0;
          if (c > 0 && upOk) mP[ch]++;
          else if (c < 0 && dnOk) mP[ch]--;
        end else mCnt[ch]++;
      end
    end
    mF = (mF + 1) % FREQ;
  endtask

  task automatic checkOutput();
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("pwm%0d", ch), longint'(pwm[ch]), longint'(mPwm[ch]));
      check($sformatf("limit%0d", ch), longint'(lim[ch]), longint'(mLim[ch]));
      check($sformatf("feedback%0d", ch), longint'(signed'(fb[32*ch +: 32])), mP[ch]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) modelReset();
    else modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic [31:0] c0, input logic [31:0] c1);
    enable = en;
    cmd = {c1, c0};
  endtask

  task automatic waitLevel(input int ch, input logic lvl, input string name);
    int n = 0;
    while (pwm[ch] !== lvl && n < 3000) begin
      tick();
      n++;
    end
    if (pwm[ch] !== lvl) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic measurePulse(input int ch, input int expW, input string name);
    int w = 0;
    waitLevel(ch, 1'b0, name);
    waitLevel(ch, 1'b1, name);
    while (pwm[ch] === 1'b1 && w < 3000) begin
      w++;
      tick();
    end
    check(name, w, expW);
  endtask

  function automatic logic [31:0] pickCmd();
    int v = int'($urandom_range(1, 12));
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      6:       return 32'h8000_0000;
      7:       return $urandom;
      default: return ($urandom_range(0, 1) == 1) ? 32'(v) : 32'(-v);
    endcase
  endfunction

  initial begin
    int n, w, lo, hi, r0, r1;
    logic [NCH-1:0] prev;

    vecs[0] = '{2'b11, 32'd0,   32'd0,        20,  0,   0,   2'b00, 1,  500};
    vecs[1] = '{2'b11, 32'd10,  32'd0,        100, 10,  0,   2'b00, -1, 0};
    vecs[2] = '{2'b11, 32'd0,   32'd0,        1,   10,  0,   2'b00, 0,  660};
    vecs[3] = '{2'b11, 32'd1,   32'd0,        40,  16,  0,   2'b01, -1, 0};
    vecs[4] = '{2'b11, -32'sd1, 32'd0,        3,   13,  0,   2'b00, -1, 0};
    vecs[5] = '{2'b11, 32'd0,   -32'sd1,      40,  13,  -16, 2'b10, -1, 0};
    vecs[6] = '{2'b11, 32'd0,   32'd0,        1,   13,  -16, 2'b00, 1,  244};
    vecs[7] = '{2'b11, 32'd0,   32'd1,        5,   13,  -11, 2'b00, -1, 0};
    vecs[8] = '{2'b11, 32'd0,   32'h8000_0000, 200, 13, -11, 2'b00, -1, 0};
    vecs[9] = '{2'b11, 32'd0,   32'd0,        1,   13,  -11, 2'b00, -1, 0};

    modelReset();
    repeat (3) tick();
    check("resetPwm", longint'(pwm), 0);
    check("resetLimit", longint'(lim), 0);
    check("resetFb", longint'(fb), 0);

    // Reset release: first rise, width and period of channel 0.
    applyStimulus(2'b11, 32'd0, 32'd0);
    rst = 1'b0;
    n = 0;
    while (pwm[0] !== 1'b1 && n < 5) begin
      tick();
      n++;
    end
    check("firstRiseEdges", (n >= 1 && n <= 2) ? 1 : 0, 1);
    w = 0;
    while (pwm[0] === 1'b1 && w < 3000) begin w++; tick(); end
    lo = 0;
    while (pwm[0] === 1'b0 && lo < 3000) begin lo++; tick(); end
    check("width0Reset", w, CENTER);
    check("period0", w + lo, FREQ);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].en, vecs[i].c0, vecs[i].c1);
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d_fb0", i), longint'(signed'(fb[31:0])), vecs[i].fb0);
      check($sformatf("vec%0d_fb1", i), longint'(signed'(fb[63:32])), vecs[i].fb1);
      check($sformatf("vec%0d_limit", i), longint'(lim), longint'(vecs[i].lim));
      if (vecs[i].pulseCh >= 0)
        measurePulse(vecs[i].pulseCh, vecs[i].pulseW, $sformatf("vec%0d_pulse", i));
    end

    // Position change in the middle of a pulse: 13 -> 10 lands in the following frame only.
    waitLevel(0, 1'b0, "midPulse");
    waitLevel(0, 1'b1, "midPulse");
    w = 0;
    while (pwm[0] === 1'b1 && w < 3000) begin
      w++;
      if (w == 50) applyStimulus(2'b11, -32'sd1, 32'd0);
      if (w == 53) applyStimulus(2'b11, 32'd0, 32'd0);
      tick();
    end
    check("midPulseWidth", w, CENTER + 13 * SCALE);
    check("midPulseFb0", longint'(signed'(fb[31:0])), 10);
    measurePulse(0, CENTER + 10 * SCALE, "nextFrameWidth");

    // Enable dropped mid-pulse, then restored while the window is still open.
    waitLevel(0, 1'b0, "enDrop");
    waitLevel(0, 1'b1, "enDrop");
    repeat (20) tick();
    applyStimulus(2'b10, 32'd3, 32'd0);
    tick();
    check("enDropPwm0", longint'(pwm[0]), 0);
    repeat (30) tick();
    check("enDropFb0", longint'(signed'(fb[31:0])), 10);
    applyStimulus(2'b11, 32'd0, 32'd0);
    hi = 0;
    repeat (100) begin
      tick();
      if (pwm[0] === 1'b1) hi++;
    end
    check("noPartialPulse", hi, 0);
    measurePulse(0, CENTER + 10 * SCALE, "reenableWidth");

    // Asynchronous reset in the middle of a pulse.
    waitLevel(0, 1'b0, "rstMid");
    waitLevel(0, 1'b1, "rstMid");
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("rstMidPwm", longint'(pwm), 0);
    check("rstMidLimit", longint'(lim), 0);
    check("rstMidFb", longint'(fb), 0);
    repeat (2) tick();
    rst = 1'b0;

    // Relative start time of channel 1 versus channel 0.
    n = 0;
    while ((pwm !== 2'b00) && n < 3000) begin tick(); n++; end
    r0 = -1; r1 = -1; n = 0;
    prev = pwm;
    while ((r0 < 0 || r1 < 0) && n < 3000) begin
      tick();
      n++;
      if (r0 < 0 && pwm[0] === 1'b1 && prev[0] === 1'b0) r0 = n;
      if (r0 >= 0 && r1 < 0 && pwm[1] === 1'b1 && prev[1] === 1'b0) r1 = n;
      prev = pwm;
    end
    check("staggerOffset", (r0 < 0 || r1 < 0) ? -1 : r1 - r0, STG_EFF);

    // Randomized run; the model comparison in tick() does the checking.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0)
        applyStimulus(2'($urandom_range(0, 3)), pickCmd(), pickCmd());
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
